ram_result_reader: RTL and testbench
====================================

// Module: ram_result_reader
// PURPOSE
//  Read-back path for the result SRAM. After the write-back stage has stored the
//  packed MU results, this block fetches NUM_WORDS consecutive words over the
//  sram_wrapper read handshake (cs_n/ry). It serialises each word MSB-first onto
//  P_out under a valid/ready handshake, then signals completion on ram_done.
// PARAMETERS
//  ADDR_W     8   SRAM address width
//  DATA_W     32  SRAM word width (= width of the write-back dataRAM)
//  NUM_WORDS  16  words read per run, 1..2**ADDR_W
//  BASE_ADDR  0   first address read
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  rd_start   in   1       1-cycle pulse starting a read-out run
//  cs_n       out  1       SRAM chip select, active-low
//  we_n       out  1       SRAM write enable, active-low; held 1 (read only)
//  address    out  ADDR_W  SRAM read address
//  read_data  in   DATA_W  SRAM read data, valid while ry=1
//  ry         in   1       SRAM ready, read data valid
//  out_ready  in   1       downstream accepts P_out this cycle
//  P_out      out  1       serial result bit, MSB of current word first
//  P_valid    out  1       P_out is valid
//  busy       out  1       run in progress (state != IDLE)
//  ram_done   out  1       1-cycle pulse after the last bit is accepted
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cs_n=1, we_n=1, address=BASE_ADDR,
//   P_out=0, P_valid=0, busy=0, ram_done=0, shift reg=0, bit_cnt=0, word_cnt=0.
//  All outputs are registered.
//  FSM states: IDLE, REQ, SHIFT, DONE.
//  IDLE: when rd_start=1, go to REQ next cycle.
//   - cs_n=0, address=BASE_ADDR, word_cnt=0.
//  REQ: cs_n stays 0 and address is held stable until ry=1.
//   - On the ry=1 edge: shreg<=read_data, cs_n<=1, P_valid<=1, bit_cnt<=0;
//     go to SHIFT.
//   - ry=0 stalls indefinitely; there is no timeout.
//   - ry is ignored while cs_n=1.
//  SHIFT: P_out = shreg[DATA_W-1].
//   - Transfer = P_valid & out_ready.
//   - On a transfer: shreg shifts left by 1 (LSB<=0), bit_cnt++.
//   - out_ready=0 holds P_out and P_valid stable.
//   - Transfer with bit_cnt=DATA_W-1 (last bit of the word):
//     - word_cnt<NUM_WORDS-1: P_valid<=0, word_cnt++, address++, cs_n<=0;
//       go to REQ.
//     - else: P_valid<=0; go to DONE.
//  DONE: ram_done=1 for exactly one cycle, then go to IDLE.
//   - address returns to BASE_ADDR.
//  Latency:
//   - rd_start to first cs_n=0: 1 cycle.
//   - ry=1 to P_valid=1: 1 cycle.
//   - Per word, best case: DATA_W cycles of shifting + 1 REQ cycle
//     + SRAM wait.
//  Boundaries:
//   - rd_start while busy=1 is ignored; no restart, no queueing.
//   - NUM_WORDS=1: DONE directly after the first word.
//   - address increments mod 2**ADDR_W. Wrap past the top is allowed when
//     BASE_ADDR+NUM_WORDS exceeds the range.
//   - rd_start coincident with ram_done: ignored (state is still DONE).
//   - Reset mid-run: immediate abort to reset values.
//     - cs_n deasserts asynchronously.
//     - No ram_done pulse.
//   - ry=1 and out_ready=1 in the same cycle are independent. No transfer
//     happens in REQ because P_valid=0.
//  Width rules: bit_cnt is clog2(DATA_W) bits; word_cnt is ADDR_W+1 bits.
// TESTING
//  1 Reset: hold rst=0 -> cs_n=1, we_n=1, P_valid=0, busy=0, ram_done=0.
//    Assert rst=0 mid-SHIFT -> all outputs return to reset values in the
//    same cycle.
//  2 Single word (NUM_WORDS=1): SRAM[0]=32'hA5000001, ry returned 2 cycles
//    after cs_n=0, out_ready=1 ->
//     - P_out stream 1010_0101_0...0_1: 32 bits on consecutive cycles.
//     - ram_done pulses 1 cycle after the last bit.
//  3 Back-pressure: toggle out_ready 1/0 every cycle on word 32'hFFFF0000
//    -> P_out held while out_ready=0; 16 ones then 16 zeros; no bit lost
//    or duplicated.
//  4 Multi-word (NUM_WORDS=4, BASE_ADDR=8'hFE): address sequence
//    FE,FF,00,01 (wrap) -> 128 serial bits match SRAM contents in order;
//    one ram_done.
//  5 rd_start pulses during busy and on the ram_done cycle -> ignored;
//    exactly one run and one ram_done.
//  6 SRAM stall: ry held 0 for 50 cycles -> cs_n stays 0, address stable,
//    P_valid=0. Then ry=1 -> stream resumes correctly.

Source files
------------

// File: rtl/ram_result_reader.sv
// Result SRAM read-back: fetches NUM_WORDS words over the cs_n/ry handshake and
// streams each one MSB-first on p_out_o under a valid/ready handshake.
module ram_result_reader #(
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 32,
   parameter int                NUM_WORDS = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rd_start_i,
   output logic              cs_n_o,
   output logic              we_n_o,
   output logic [ADDR_W-1:0] address_o,
   input  logic [DATA_W-1:0] read_data_i,
   input  logic              ry_i,
   input  logic              out_ready_i,
   output logic              p_out_o,
   output logic              p_valid_o,
   output logic              busy_o,
   output logic              ram_done_o
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(NUM_WORDS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic              cs_n_q,     cs_n_d;
   logic [ADDR_W-1:0] address_q,  address_d;
   logic [DATA_W-1:0] shreg_q,    shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic              p_valid_q,  p_valid_d;
   logic              busy_q,     busy_d;
   logic              ram_done_q, ram_done_d;
   logic              xfer_s;

   assign xfer_s = p_valid_q & out_ready_i;

   // Next-state and datapath decisions for the read-out FSM
   always_comb begin
      state_d    = state_q;
      cs_n_d     = cs_n_q;
      address_d  = address_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      p_valid_d  = p_valid_q;
      ram_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_start_i) begin
               state_d    = REQ;
               cs_n_d     = 1'b0;
               address_d  = BASE_ADDR;
               word_cnt_d = {(ADDR_W + 1){1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (ry_i && !cs_n_q) begin
               shreg_d   = read_data_i;
               cs_n_d    = 1'b1;
               p_valid_d = 1'b1;
               bit_cnt_d = {CNT_W{1'b0}};
               state_d   = SHIFT;
            end else begin
               state_d = REQ;
            end
         end
         SHIFT: begin
            if (xfer_s) begin
               shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  p_valid_d = 1'b0;
                  // Address wraps naturally at the top of the SRAM range
                  if (word_cnt_q < LAST_WORD) begin
                     word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
                     address_d  = address_q + ADDR_W'(1);
                     cs_n_d     = 1'b0;
                     state_d    = REQ;
                  end else begin
                     address_d  = BASE_ADDR;
                     ram_done_d = 1'b1;
                     state_d    = DONE;
                  end
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cs_n_q     <= 1'b1;
         address_q  <= BASE_ADDR;
         shreg_q    <= {DATA_W{1'b0}};
         bit_cnt_q  <= {CNT_W{1'b0}};
         word_cnt_q <= {(ADDR_W + 1){1'b0}};
         p_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         ram_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cs_n_q     <= cs_n_d;
         address_q  <= address_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         p_valid_q  <= p_valid_d;
         busy_q     <= busy_d;
         ram_done_q <= ram_done_d;
      end
   end

   assign cs_n_o     = cs_n_q;
   assign we_n_o     = 1'b1;
   assign address_o  = address_q;
   assign p_out_o    = shreg_q[DATA_W-1];
   assign p_valid_o  = p_valid_q;
   assign busy_o     = busy_q;
   assign ram_done_o = ram_done_q;

endmodule

// File: tb/tb_ram_result_reader.sv
// Bench for ram_result_reader: one single-word instance (base 00) and one
// four-word instance (base FE), a small SRAM model and a bit-stream scoreboard.
module tb_ram_result_reader;

   typedef struct packed {
      int              sel;
      int              ry_dly;
      int              bp;
      bit              spam;
      int              nw;
      logic [3:0][31:0] w;
      logic [3:0][7:0]  a;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  rd_start, cs_n, we_n, ry, p_out, p_valid, busy, ram_done;
   logic        out_ready;
   logic [7:0]  addr [2];
   logic [31:0] rdata [2];
   logic [31:0] mem [256];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   sel = 0;
   int   ry_dly = 0;
   int   bp = 0;
   bit   spam = 1'b0;
   int   wait_cnt = 0;
   bit   ry_given = 1'b0;
   bit   chk_req = 1'b0;
   bit   prev_hold = 1'b0;
   logic prev_bit = 1'b0;
   int   last_xfer = 0;
   int   done_cnt = 0;
   bit   exp_bits[$];
   logic [7:0] exp_addr[$];
   logic [7:0] base [2];
   vec_t vecs [6];

   always #5 clk = ~clk;

   ram_result_reader #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(1), .BASE_ADDR(8'h00)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .rd_start_i(rd_start[0]), .cs_n_o(cs_n[0]),
      .we_n_o(we_n[0]), .address_o(addr[0]), .read_data_i(rdata[0]), .ry_i(ry[0]),
      .out_ready_i(out_ready), .p_out_o(p_out[0]), .p_valid_o(p_valid[0]),
      .busy_o(busy[0]), .ram_done_o(ram_done[0]));

   ram_result_reader #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(4), .BASE_ADDR(8'hFE)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .rd_start_i(rd_start[1]), .cs_n_o(cs_n[1]),
      .we_n_o(we_n[1]), .address_o(addr[1]), .read_data_i(rdata[1]), .ry_i(ry[1]),
      .out_ready_i(out_ready), .p_out_o(p_out[1]), .p_valid_o(p_valid[1]),
      .busy_o(busy[1]), .ram_done_o(ram_done[1]));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock of SRAM model, downstream driver and scoreboard for DUT 'sel'
   task automatic step(input bit start);
      int k;
      @(negedge clk);
      cyc++;
      k = sel;
      if (ry_given) begin
         check("ry_to_valid", {31'd0, p_valid[k]}, 32'd1);
         ry_given = 1'b0;
      end
      if (chk_req) begin
         check("start_to_cs", {31'd0, cs_n[k]}, 32'd0);
         chk_req = 1'b0;
      end
      ry = 2'b00;
      rdata[0] = $urandom;
      rdata[1] = $urandom;
      if (!cs_n[k]) begin
         if (exp_addr.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
         end else begin
            check("address", {24'd0, addr[k]}, {24'd0, exp_addr[0]});
         end
         check("valid_in_req", {31'd0, p_valid[k]}, 32'd0);
         if (wait_cnt >= ry_dly) begin
            ry[k] = 1'b1;
            rdata[k] = mem[addr[k]];
            if (exp_addr.size() > 0) void'(exp_addr.pop_front());
            wait_cnt = 0;
            ry_given = 1'b1;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      case (bp)
         0: out_ready = 1'b1;
         1: out_ready = cyc[0];
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_hold) begin
         check("hold_valid", {31'd0, p_valid[k]}, 32'd1);
         check("hold_bit", {31'd0, p_out[k]}, {31'd0, prev_bit});
      end
      prev_hold = p_valid[k] && !out_ready;
      prev_bit  = p_out[k];
      if (p_valid[k] && out_ready) begin
         if (exp_bits.size() == 0) begin
            check("extra_bit", 32'd1, 32'd0);
         end else begin
            check("bit", {31'd0, p_out[k]}, {31'd0, exp_bits.pop_front()});
         end
         last_xfer = cyc;
      end
      if (ram_done[k]) begin
         done_cnt++;
         check("done_timing", cyc, last_xfer + 1);
         check("bits_left_at_done", exp_bits.size(), 32'd0);
      end
      rd_start = 2'b00;
      rd_start[k] = start || (spam && busy[k]);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      int done0;
      sel = v.sel; ry_dly = v.ry_dly; bp = v.bp; spam = v.spam;
      prev_hold = 1'b0; wait_cnt = 0;
      for (int i = 0; i < v.nw; i++) begin
         mem[v.a[i]] = v.w[i];
         exp_addr.push_back(v.a[i]);
         for (int b = 31; b >= 0; b--) exp_bits.push_back(v.w[i][b]);
      end
      done0 = done_cnt;
      step(1'b1);
      chk_req = 1'b1;
      n = 0;
      while (done_cnt == done0 && n < 3000) begin
         step(1'b0);
         n++;
      end
      if (done_cnt == done0) check("run_timeout", 32'd1, 32'd0);
      for (int i = 0; i < 30; i++) step(1'b0);
      check("done_count", done_cnt, done0 + 1);
      check("busy_after", {31'd0, busy[sel]}, 32'd0);
      check("cs_n_after", {31'd0, cs_n[sel]}, 32'd1);
      check("addr_after", {24'd0, addr[sel]}, {24'd0, base[sel]});
      check("bits_left", exp_bits.size(), 32'd0);
      exp_bits.delete();
      exp_addr.delete();
   endtask

   task automatic abort_run(input bit in_shift);
      int n;
      int done0;
      sel = 1; ry_dly = 4; bp = 0; spam = 1'b0; prev_hold = 1'b0; wait_cnt = 0;
      mem[8'hFE] = 32'hC3C3_5A5A;
      exp_addr.push_back(8'hFE);
      for (int b = 31; b >= 0; b--) exp_bits.push_back(mem[8'hFE][b]);
      done0 = done_cnt;
      step(1'b1);
      chk_req = 1'b1;
      n = 0;
      while (n < 20 && !(in_shift ? p_valid[1] : !cs_n[1])) begin
         step(1'b0);
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort_cs_n", {31'd0, cs_n[1]}, 32'd1);
      check("abort_valid", {31'd0, p_valid[1]}, 32'd0);
      check("abort_busy", {31'd0, busy[1]}, 32'd0);
      check("abort_pout", {31'd0, p_out[1]}, 32'd0);
      check("abort_addr", {24'd0, addr[1]}, 32'h0000_00FE);
      exp_bits.delete();
      exp_addr.delete();
      ry_given = 1'b0; chk_req = 1'b0; prev_hold = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b0);
      check("abort_no_done", done_cnt, done0);
   endtask

   initial begin
      base[0] = 8'h00;
      base[1] = 8'hFE;
      rst_n = 1'b0; rd_start = 2'b00; ry = 2'b00; out_ready = 1'b0;
      rdata[0] = 32'd0; rdata[1] = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;

      for (int i = 0; i < 6; i++) vecs[i] = '0;
      vecs[0].sel = 0; vecs[0].ry_dly = 2;  vecs[0].bp = 0; vecs[0].nw = 1;
      vecs[0].w[0] = 32'hA500_0001; vecs[0].a[0] = 8'h00;
      vecs[1].sel = 0; vecs[1].ry_dly = 1;  vecs[1].bp = 1; vecs[1].nw = 1;
      vecs[1].w[0] = 32'hFFFF_0000; vecs[1].a[0] = 8'h00;
      vecs[2].sel = 1; vecs[2].ry_dly = 1;  vecs[2].bp = 0; vecs[2].nw = 4;
      vecs[2].w = {32'hF0F0_0F0F, 32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF};
      vecs[2].a = {8'h01, 8'h00, 8'hFF, 8'hFE};
      vecs[3].sel = 1; vecs[3].ry_dly = 0;  vecs[3].bp = 2; vecs[3].spam = 1'b1; vecs[3].nw = 4;
      vecs[3].w = {32'h1357_9BDF, 32'h8000_0000, 32'h0000_0001, 32'hCAFE_F00D};
      vecs[3].a = {8'h01, 8'h00, 8'hFF, 8'hFE};
      vecs[4].sel = 1; vecs[4].ry_dly = 50; vecs[4].bp = 0; vecs[4].nw = 4;
      vecs[4].w = {32'h7777_8888, 32'h5555_AAAA, 32'h3C3C_C3C3, 32'h9696_6969};
      vecs[4].a = {8'h01, 8'h00, 8'hFF, 8'hFE};
      vecs[5].sel = 0; vecs[5].ry_dly = 0;  vecs[5].bp = 2; vecs[5].spam = 1'b1; vecs[5].nw = 1;
      vecs[5].w[0] = 32'h8000_0001; vecs[5].a[0] = 8'h00;

      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_cs_n", {31'd0, cs_n[k]}, 32'd1);
         check("rst_we_n", {31'd0, we_n[k]}, 32'd1);
         check("rst_valid", {31'd0, p_valid[k]}, 32'd0);
         check("rst_busy", {31'd0, busy[k]}, 32'd0);
         check("rst_done", {31'd0, ram_done[k]}, 32'd0);
         check("rst_pout", {31'd0, p_out[k]}, 32'd0);
         check("rst_addr", {24'd0, addr[k]}, {24'd0, base[k]});
      end
      rst_n = 1'b1;
      repeat (2) step(1'b0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      abort_run(1'b1);
      abort_run(1'b0);
      check("we_n_idle", {31'd0, we_n[1]}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
